feature_packet_spi_tx: RTL and testbench
========================================

FEATURE_PACKET_SPI_TX -- requirements
Module: feature_packet_spi_tx

Interface
REQ-001 SHALL have parameter NUM_BITS_X, default 10, meaning X-coordinate width (1..16).
REQ-002 SHALL have parameter NUM_BITS_Y, default 9, meaning Y-coordinate width (1..16).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 8, meaning feature-memory address width (1..16).
REQ-004 SHALL have parameter MSB_FIRST, default 0, meaning feature byte order (0: least-significant byte first).
REQ-005 Derived quantities: FW = 2*(NUM_BITS_X+NUM_BITS_Y); B = ceil(FW/8) bytes per feature, zero-padded in the MSBs.
REQ-006 Port: systemClock  in  1  sole clock, rising edge.
REQ-007 Port: nReset  in  1  asynchronous, active-low reset.
REQ-008 Port: start  in  1  single-cycle request to send one packet.
REQ-009 Port: frameCount  in  8  frame number, sampled on accepted start.
REQ-010 Port: featureCount  in  ADDRESS_WIDTH  number of features N, sampled on accepted start.
REQ-011 Port: readAddress  out  ADDRESS_WIDTH  feature-memory address.
REQ-012 Port: readData  in  FW  feature at readAddress, valid exactly 1 cycle after the address.
REQ-013 Port: txData  out  8  byte to the SPI master.
REQ-014 Port: txValid  out  1  txData valid.
REQ-015 Port: txReady  in  1  SPI master can accept a byte.
REQ-016 Port: busy  out  1  packet in progress.
REQ-017 Port: done  out  1  one-cycle pulse when a packet completes.
REQ-018 Port: overrun  out  1  one-cycle pulse when a packet is aborted.

Function
REQ-019 Packet byte order SHALL be: 0xA5, frameCount, N[7:0], N[15:8] (zero-extended), then N*B feature bytes, then the optional CRC (REQ-033).
REQ-020 A byte SHALL transfer on a cycle where txValid and txReady are both 1; while txValid=1 and txReady=0, txData SHALL hold stable.
REQ-021 The FSM SHALL have states IDLE, HDR, FETCH, LOAD, FEAT, CRC, DONE.
REQ-022 IDLE: start=1 -> HDR; latch frameCount and featureCount; byte index=0; busy rises on the next cycle.
REQ-023 HDR: after the 4th header byte transfers -> FETCH if N>0; otherwise -> CRC if enabled, else DONE.
REQ-024 FETCH: drive readAddress=k, where k is the feature index starting at 0 -> LOAD (one cycle).
REQ-025 LOAD: latch readData into a zero-padded shift register -> FEAT; txValid SHALL be 0 in FETCH and LOAD.
REQ-026 FEAT: send B bytes, LSB byte first if MSB_FIRST=0 and MSB byte first otherwise.
REQ-027 FEAT, after the last byte: k+1<N -> FETCH with k+1; otherwise -> CRC or DONE.
REQ-028 DONE: done=1 for one cycle, busy=0 -> IDLE; a start in the DONE cycle SHALL be ignored.
REQ-029 A start while busy=1 SHALL abort the packet: txValid drops next cycle, overrun pulses, state -> IDLE, no done pulse, and the start itself is not accepted.
REQ-030 The first txValid SHALL assert the cycle after an accepted start; header bytes SHALL be emitted back-to-back when txReady is held at 1.
REQ-031 The feature index SHALL be ADDRESS_WIDTH+1 bits wide so that N = 2^ADDRESS_WIDTH-1 completes without wrap-around.

Reset
REQ-032 nReset=0 SHALL immediately force state IDLE and set txValid, busy, done, overrun to 0, txData, readAddress and all counters to 0, and the CRC to 0x00, including mid-packet.

Configuration
REQ-033 Macro FEATURE_PACKET_SPI_CRC_EN defined: after the last feature byte (or after the header when N=0), send one CRC-8 byte (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) computed over all preceding packet bytes.
REQ-034 Macro FEATURE_PACKET_SPI_CRC_EN undefined: no CRC state or logic; packet ends after the last feature byte.

Verification
REQ-035 N=0, frameCount=0x03, txReady=1: bytes A5 03 00 00, then 0x0C when CRC is enabled, then done=1 for one cycle.
REQ-036 Defaults (B=5), N=2, mem[0]=0x12_3456_789A, mem[1]=0x3F_FFFF_FFFF, MSB_FIRST=0: feature bytes 9A 78 56 34 12 FF FF FF FF 3F; readAddress sequence 0 then 1.
REQ-037 Same as REQ-036 with MSB_FIRST=1: feature bytes 12 34 56 78 9A 3F FF FF FF FF.
REQ-038 txReady toggled randomly, 0-5 idle cycles per byte: byte stream identical to REQ-036; txData stable while stalled.
REQ-039 start reasserted during the 3rd feature byte: overrun=1 for one cycle, txValid=0 next cycle, busy=0, no done; a later start sends a full packet.
REQ-040 nReset pulsed low mid-FEAT: all outputs 0 asynchronously; the next start produces a correct complete packet; ADDRESS_WIDTH=4 with N=15: 4+75 bytes (+CRC), no wrap.

Source files
------------

// File: rtl/feature_packet_spi_tx_if.sv
// Bundles the packet request, feature-memory read port and byte stream of feature_packet_spi_tx.
// Byte handshake: a byte moves on a rising edge where txValid and txReady are both 1; txData holds while txValid=1 and txReady=0.
interface feature_packet_spi_tx_if #(
    parameter int NUM_BITS_X    = 10,
    parameter int NUM_BITS_Y    = 9,
    parameter int ADDRESS_WIDTH = 8
);
    localparam int FW = 2 * (NUM_BITS_X + NUM_BITS_Y);

    logic                     start;
    logic [7:0]               frameCount;
    logic [ADDRESS_WIDTH-1:0] featureCount;
    logic [ADDRESS_WIDTH-1:0] readAddress;
    logic [FW-1:0]            readData;
    logic [7:0]               txData;
    logic                     txValid;
    logic                     txReady;
    logic                     busy;
    logic                     done;
    logic                     overrun;
    logic [2:0]               dbg_state;

    modport master (
        output start, frameCount, featureCount, readData, txReady,
        input  readAddress, txData, txValid, busy, done, overrun, dbg_state
    );

    modport slave (
        input  start, frameCount, featureCount, readData, txReady,
        output readAddress, txData, txValid, busy, done, overrun, dbg_state
    );
endinterface

// File: rtl/feature_packet_spi_tx.sv
// Serialises a header plus N feature words from memory into a byte stream for an SPI master.
// Define FEATURE_PACKET_SPI_CRC_EN to append a CRC-8 (poly 0x07) byte over the whole packet.
module feature_packet_spi_tx #(
    parameter int NUM_BITS_X    = 10,
    parameter int NUM_BITS_Y    = 9,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MSB_FIRST     = 0
) (
    input logic                    systemClock,
    input logic                    nReset,
    feature_packet_spi_tx_if.slave bus
);
    localparam int FW = 2 * (NUM_BITS_X + NUM_BITS_Y);
    localparam int B  = (FW + 7) / 8;
    localparam int SW = 8 * B;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        FEAT  = 3'd4,
        DONE  = 3'd5
`ifdef FEATURE_PACKET_SPI_CRC_EN
        , CRC = 3'd6
`endif
    } state_t;

    state_t                   state;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     busy_q;
    logic                     done_q;
    logic                     overrun_q;
    logic [ADDRESS_WIDTH-1:0] read_addr;
    logic [7:0]               frame_q;
    logic [ADDRESS_WIDTH-1:0] count_q;
    logic [ADDRESS_WIDTH:0]   feat_idx;
    logic [3:0]               byte_idx;
    logic [SW-1:0]            shreg;

    logic                     xfer;
    logic [15:0]              n16;
    logic [7:0]               hdr_next;
    logic [ADDRESS_WIDTH:0]   feat_next;
    logic                     more_feats;
    logic [SW-1:0]            padded;
    logic [7:0]               load_byte;
    logic [SW-1:0]            load_rest;
    logic [7:0]               next_byte;
    logic [SW-1:0]            next_rest;

    assign xfer       = tx_valid && bus.txReady;
    assign n16        = 16'(count_q);
    assign feat_next  = feat_idx + 1'b1;
    assign more_feats = feat_next < {1'b0, count_q};

    always_comb begin
        hdr_next = frame_q;
        case (byte_idx)
            4'd1:    hdr_next = n16[7:0];
            4'd2:    hdr_next = n16[15:8];
            default: hdr_next = frame_q;
        endcase
    end

    // The byte on the wire is always taken from one end of the shift register.
    always_comb begin
        padded = SW'(bus.readData);
        if (MSB_FIRST != 0) begin
            load_byte = padded[SW-1 -: 8];
            load_rest = padded << 8;
            next_byte = shreg[SW-1 -: 8];
            next_rest = shreg << 8;
        end else begin
            load_byte = padded[7:0];
            load_rest = padded >> 8;
            next_byte = shreg[7:0];
            next_rest = shreg >> 8;
        end
    end

`ifdef FEATURE_PACKET_SPI_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    assign crc_next = crc8_byte(crc_q, tx_data);
`endif

    always_ff @(posedge systemClock or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            read_addr <= '0;
            frame_q   <= '0;
            count_q   <= '0;
            feat_idx  <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
`ifdef FEATURE_PACKET_SPI_CRC_EN
            crc_q     <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            // A new request while a packet is in flight kills it; the request itself is dropped.
            if (busy_q && bus.start) begin
                state     <= IDLE;
                tx_valid  <= 1'b0;
                busy_q    <= 1'b0;
                overrun_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state    <= HDR;
                            frame_q  <= bus.frameCount;
                            count_q  <= bus.featureCount;
                            byte_idx <= '0;
                            feat_idx <= '0;
                            tx_data  <= 8'hA5;
                            tx_valid <= 1'b1;
                            busy_q   <= 1'b1;
`ifdef FEATURE_PACKET_SPI_CRC_EN
                            crc_q    <= '0;
`endif
                        end
                    end
                    HDR: begin
                        if (xfer) begin
`ifdef FEATURE_PACKET_SPI_CRC_EN
                            crc_q <= crc_next;
`endif
                            if (byte_idx == 4'd3) begin
                                if (count_q != '0) begin
                                    state     <= FETCH;
                                    read_addr <= '0;
                                    tx_valid  <= 1'b0;
                                end else begin
`ifdef FEATURE_PACKET_SPI_CRC_EN
                                    state    <= CRC;
                                    tx_data  <= crc_next;
                                    tx_valid <= 1'b1;
`else
                                    state    <= DONE;
                                    tx_valid <= 1'b0;
                                    busy_q   <= 1'b0;
                                    done_q   <= 1'b1;
`endif
                                end
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                                tx_data  <= hdr_next;
                            end
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        shreg    <= load_rest;
                        tx_data  <= load_byte;
                        tx_valid <= 1'b1;
                        byte_idx <= '0;
                        state    <= FEAT;
                    end
                    FEAT: begin
                        if (xfer) begin
`ifdef FEATURE_PACKET_SPI_CRC_EN
                            crc_q <= crc_next;
`endif
                            if (byte_idx == 4'(B - 1)) begin
                                if (more_feats) begin
                                    feat_idx  <= feat_next;
                                    read_addr <= feat_next[ADDRESS_WIDTH-1:0];
                                    state     <= FETCH;
                                    tx_valid  <= 1'b0;
                                end else begin
`ifdef FEATURE_PACKET_SPI_CRC_EN
                                    state    <= CRC;
                                    tx_data  <= crc_next;
                                    tx_valid <= 1'b1;
`else
                                    state    <= DONE;
                                    tx_valid <= 1'b0;
                                    busy_q   <= 1'b0;
                                    done_q   <= 1'b1;
`endif
                                end
                            end else begin
                                byte_idx <= byte_idx + 4'd1;
                                tx_data  <= next_byte;
                                shreg    <= next_rest;
                            end
                        end
                    end
`ifdef FEATURE_PACKET_SPI_CRC_EN
                    CRC: begin
                        if (xfer) begin
                            state    <= DONE;
                            tx_valid <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
`endif
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.txData      = tx_data;
    assign bus.txValid     = tx_valid;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.overrun     = overrun_q;
    assign bus.readAddress = read_addr;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_feature_packet_spi_tx.sv
// Bench for feature_packet_spi_tx: an LSB-first default instance and an MSB-first ADDRESS_WIDTH=4 instance in lock-step.
module tb_feature_packet_spi_tx;
    localparam int FW = 38;
    localparam int B  = 5;
`ifdef FEATURE_PACKET_SPI_CRC_EN
    localparam int CRC_X = 1;
`else
    localparam int CRC_X = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    feature_packet_spi_tx_if #(.NUM_BITS_X(10), .NUM_BITS_Y(9), .ADDRESS_WIDTH(8)) bus_a ();
    feature_packet_spi_tx_if #(.NUM_BITS_X(10), .NUM_BITS_Y(9), .ADDRESS_WIDTH(4)) bus_b ();

    feature_packet_spi_tx #(.NUM_BITS_X(10), .NUM_BITS_Y(9), .ADDRESS_WIDTH(8), .MSB_FIRST(0)) dut_a (
        .systemClock(clk), .nReset(rst_n), .bus(bus_a));
    feature_packet_spi_tx #(.NUM_BITS_X(10), .NUM_BITS_Y(9), .ADDRESS_WIDTH(4), .MSB_FIRST(1)) dut_b (
        .systemClock(clk), .nReset(rst_n), .bus(bus_b));

    logic       start;
    logic [7:0] frame;
    logic [7:0] count;
    logic       ready;

    assign bus_a.start = start;  assign bus_b.start = start;
    assign bus_a.frameCount = frame;  assign bus_b.frameCount = frame;
    assign bus_a.featureCount = count;  assign bus_b.featureCount = count[3:0];
    assign bus_a.txReady = ready;  assign bus_b.txReady = ready;

    logic [FW-1:0] mem [0:255];
    always @(posedge clk) begin
        bus_a.readData <= mem[bus_a.readAddress];
        bus_b.readData <= mem[bus_b.readAddress];
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] log_a[$];
    logic [7:0] log_b[$];
    logic [7:0] addr_log[$];
    int checks = 0;
    int passes = 0;
    int done_a = 0;
    int ovr_a  = 0;
    logic       pend_a = 1'b0, pend_b = 1'b0;
    logic [7:0] held_a = '0, held_b = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] crc_model(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_a && bus_a.txValid) check("a_stall_stable", bus_a.txData, held_a);
            if (pend_b && bus_b.txValid) check("b_stall_stable", bus_b.txData, held_b);
            pend_a = bus_a.txValid && !ready;  held_a = bus_a.txData;
            pend_b = bus_b.txValid && !ready;  held_b = bus_b.txData;
            if (bus_a.txValid && ready) begin
                log_a.push_back(bus_a.txData);
                if (exp_a.size() > 0) check("a_byte", bus_a.txData, exp_a.pop_front());
                else check("a_extra_byte", 64'(bus_a.txData), 64'h100);
            end
            if (bus_b.txValid && ready) begin
                log_b.push_back(bus_b.txData);
                if (exp_b.size() > 0) check("b_byte", bus_b.txData, exp_b.pop_front());
                else check("b_extra_byte", 64'(bus_b.txData), 64'h100);
            end
            if (bus_a.done) begin
                done_a++;
                check("a_done_not_busy", bus_a.busy, 0);
            end
            if (bus_a.overrun) ovr_a++;
            if (bus_a.dbg_state == 3'd2) addr_log.push_back(bus_a.readAddress);
        end else begin
            pend_a = 1'b0;
            pend_b = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_packet(input logic [7:0] fr, input int n);
        logic [7:0] hdr[4];
        logic [39:0] w;
        logic [7:0] ca, cb, ba, bb;
        hdr[0] = 8'hA5; hdr[1] = fr; hdr[2] = 8'(n); hdr[3] = 8'h00;
        ca = 8'h00; cb = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(hdr[i]); exp_b.push_back(hdr[i]);
            ca = crc_model(ca, hdr[i]); cb = crc_model(cb, hdr[i]);
        end
        for (int k = 0; k < n; k++) begin
            w = 40'(mem[k]);
            for (int j = 0; j < B; j++) begin
                ba = w[8*j +: 8];
                bb = w[8*(B-1-j) +: 8];
                exp_a.push_back(ba); exp_b.push_back(bb);
                ca = crc_model(ca, ba); cb = crc_model(cb, bb);
            end
        end
        if (CRC_X != 0) begin
            exp_a.push_back(ca); exp_b.push_back(cb);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a_valid"}, bus_a.txValid, 0);    check({tag, "_b_valid"}, bus_b.txValid, 0);
        check({tag, "_a_busy"}, bus_a.busy, 0);        check({tag, "_b_busy"}, bus_b.busy, 0);
        check({tag, "_a_done"}, bus_a.done, 0);        check({tag, "_a_overrun"}, bus_a.overrun, 0);
        check({tag, "_a_data"}, bus_a.txData, 0);      check({tag, "_b_data"}, bus_b.txData, 0);
        check({tag, "_a_addr"}, bus_a.readAddress, 0); check({tag, "_b_addr"}, bus_b.readAddress, 0);
        check({tag, "_a_state"}, bus_a.dbg_state, 0);  check({tag, "_b_state"}, bus_b.dbg_state, 0);
    endtask

    task automatic launch(input logic [7:0] fr, input int n, input logic first_ready);
        @(posedge clk); #1;
        frame = fr; count = 8'(n); start = 1'b1; ready = first_ready;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_packet(input logic [7:0] fr, input int n, input bit stall, input int exp_cyc);
        int  d0, cyc, idle_left;
        bit  seen, xfer;
        expect_packet(fr, n);
        log_a.delete(); log_b.delete(); addr_log.delete();
        d0 = done_a; seen = 0;
        idle_left = stall ? $urandom_range(0, 5) : 0;
        launch(fr, n, idle_left == 0);
        @(negedge clk); cyc = 1;
        check("first_valid", bus_a.txValid, 1);
        check("first_byte", bus_a.txData, 8'hA5);
        check("busy_rises", bus_a.busy, 1);
        while (!seen && cyc < 3000) begin
            if (bus_a.done) seen = 1;
            else begin
                xfer = bus_a.txValid && ready;
                @(posedge clk); #1;
                if (stall) begin
                    if (xfer) idle_left = $urandom_range(0, 5);
                    else if (idle_left > 0) idle_left--;
                    ready = (idle_left == 0);
                end
                @(negedge clk); cyc++;
            end
        end
        check("done_seen", seen, 1);
        check("b_done_with_a", bus_b.done, 1);
        if (exp_cyc > 0) check("packet_cycles", cyc, exp_cyc);
        ready = 1'b1;
        @(negedge clk);
        check("done_one_cycle", bus_a.done, 0);
        check("back_to_idle", bus_a.dbg_state, 0);
        check("a_all_bytes_sent", exp_a.size(), 0);
        check("b_all_bytes_sent", exp_b.size(), 0);
        check("one_done_pulse", done_a - d0, 1);
        exp_a.delete(); exp_b.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] frame;
        int         n;
        bit         stall;
        int         exp_cyc;
    } vec_t;
    vec_t vecs[6];
    logic [7:0] lsb_bytes[10];
    logic [7:0] msb_bytes[10];
    logic [7:0] hdr0[4];

    initial begin
        int o0;
        start = 1'b0; frame = '0; count = '0; ready = 1'b1;
        mem[0] = 38'h12_3456_789A;
        mem[1] = 38'h3F_FFFF_FFFF;
        for (int i = 2; i < 256; i++) mem[i] = FW'(64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
        lsb_bytes = '{8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F};
        msb_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h3F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        hdr0 = '{8'hA5, 8'h03, 8'h00, 8'h00};
        vecs[0] = '{8'h03, 0, 1'b0, 5 + CRC_X};
        vecs[1] = '{8'h5C, 2, 1'b0, 19 + CRC_X};
        vecs[2] = '{8'h5C, 2, 1'b1, 0};
        vecs[3] = '{8'hE1, 15, 1'b0, 110 + CRC_X};
        vecs[4] = '{8'h7F, 1, 1'b1, 0};
        vecs[5] = '{8'h00, 3, 1'b0, 26 + CRC_X};

        repeat (3) @(posedge clk);
        #1 check_idle("in_reset");
        rst_n = 1'b1;
        @(negedge clk) check_idle("after_reset");

        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                // Abort: second start during the third feature byte.
                expect_packet(8'h44, 2);
                o0 = ovr_a;
                launch(8'h44, 2, 1'b1);
                repeat (9) @(negedge clk);
                check("abort_at_third_feat_a", bus_a.txData, 8'h56);
                check("abort_at_third_feat_b", bus_b.txData, 8'h56);
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                @(negedge clk);
                check("abort_overrun", bus_a.overrun, 1);
                check("abort_b_overrun", bus_b.overrun, 1);
                check("abort_valid_low", bus_a.txValid, 0);
                check("abort_busy_low", bus_a.busy, 0);
                check("abort_no_done", bus_a.done, 0);
                check("abort_remaining", exp_a.size(), 7 + CRC_X);
                @(negedge clk);
                check("abort_overrun_pulse", bus_a.overrun, 0);
                check("abort_start_dropped", bus_a.busy, 0);
                check("abort_state_idle", bus_a.dbg_state, 0);
                check("abort_overrun_count", ovr_a - o0, 1);
                exp_a.delete(); exp_b.delete();
            end
            run_packet(vecs[i].frame, vecs[i].n, vecs[i].stall, vecs[i].exp_cyc);
            if (i == 0) begin
                for (int j = 0; j < 4; j++) check("n0_header", log_a[j], hdr0[j]);
                if (CRC_X != 0) check("n0_crc", log_a[4], 8'h0C);
            end
            if (i == 1 || i == 2) begin
                for (int j = 0; j < 10; j++) begin
                    check("lsb_first_bytes", log_a[4+j], lsb_bytes[j]);
                    check("msb_first_bytes", log_b[4+j], msb_bytes[j]);
                end
                check("addr_count", addr_log.size(), 2);
                if (addr_log.size() == 2) begin
                    check("addr_0", addr_log[0], 0);
                    check("addr_1", addr_log[1], 1);
                end
            end
            if (i == 3) check("n15_length", log_b.size(), 79 + CRC_X);
        end

        // Ignored start in the DONE cycle.
        expect_packet(8'h09, 0);
        launch(8'h09, 0, 1'b1);
        for (int c = 0; c < 20 && !bus_a.done; c++) @(negedge clk);
        check("done_cycle_reached", bus_a.done, 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", bus_a.busy, 0);
        check("start_in_done_state", bus_a.dbg_state, 0);
        @(negedge clk);
        check("start_in_done_no_valid", bus_a.txValid, 0);
        exp_a.delete(); exp_b.delete();

        // Asynchronous reset in the middle of a feature.
        expect_packet(8'h21, 2);
        launch(8'h21, 2, 1'b1);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("mid_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        exp_a.delete(); exp_b.delete();
        run_packet(8'hB7, 2, 1'b1, 0);
        run_packet(8'h3C, 15, 1'b1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
